// File: rtl/march_pkg.sv
// rtl/march_pkg.sv - March C- shared types and element/op tables
package march_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int NUM_ELEMS = 6;
  localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEMS - 1);

  // Bit e: element e sweeps upward / element e has a read followed by a write.
  localparam logic [NUM_ELEMS-1:0] ELEM_UP      = 6'b000111;
  localparam logic [NUM_ELEMS-1:0] ELEM_TWO_OPS = 6'b011110;

  // Bit {elem, op}: the op is a write / the op uses D1 (~B) rather than D0 (B).
  localparam logic [2*NUM_ELEMS-1:0] OP_WRITE = 12'b0010_1010_1001;
  localparam logic [2*NUM_ELEMS-1:0] OP_INV   = 12'b0001_1001_1000;

  function automatic logic [3:0] op_index(input logic [2:0] elem, input logic op);
    return {elem, op};
  endfunction

endpackage

// File: rtl/march_bist_if.sv
// rtl/march_bist_if.sv - test-control and memory-port bundle of one BIST instance
interface march_bist_if #(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 8
) ();

  logic                 start;
  logic [DATA_BITS-1:0] pattern;
  logic                 busy;
  logic                 done;
  logic                 fail;
  logic [ADDR_BITS-1:0] fail_addr;
  logic [2:0]           fail_elem;
  logic [CNT_BITS-1:0]  err_count;
  logic                 mem_we;
  logic [ADDR_BITS-1:0] mem_addr;
  logic [DATA_BITS-1:0] mem_wdata;
  logic [DATA_BITS-1:0] mem_rdata;

  modport master (
    input  start, pattern, mem_rdata,
    output busy, done, fail, fail_addr, fail_elem, err_count,
    output mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output start, pattern, mem_rdata,
    input  busy, done, fail, fail_addr, fail_elem, err_count,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/march_addr_gen.sv
// rtl/march_addr_gen.sv - loadable up/down address counter with first/last flags
module march_addr_gen #(
  parameter int ADDR_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_i,
  input  logic                 up_i,
  input  logic                 step_i,
  output logic [ADDR_BITS-1:0] addr_o,
  output logic                 first_o,
  output logic                 last_o
);

  localparam logic [ADDR_BITS-1:0] ADDR_MAX = '1;

  logic [ADDR_BITS-1:0] addr_q;
  logic                 up_q;

  // A step at the element's last address is ignored: no wrap inside an element.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      up_q   <= 1'b1;
    end else if (load_i) begin
      addr_q <= up_i ? '0 : ADDR_MAX;
      up_q   <= up_i;
    end else if (step_i && !last_o) begin
      addr_q <= up_q ? addr_q + 1'b1 : addr_q - 1'b1;
    end
  end

  assign addr_o  = addr_q;
  assign first_o = up_q ? (addr_q == '0) : (addr_q == ADDR_MAX);
  assign last_o  = up_q ? (addr_q == ADDR_MAX) : (addr_q == '0);

endmodule

// File: rtl/march_bist.sv
// rtl/march_bist.sv - March C- memory BIST: sequencing, compare and result capture
module march_bist
  import march_pkg::*;
#(
  parameter int ADDR_BITS = 5,
  parameter int DATA_BITS = 8,
  parameter int CNT_BITS  = 8
) (
  input logic         clk,
  input logic         reset,
  march_bist_if.master bus
);

  state_t               state_q;
  logic [2:0]           elem_q;
  logic                 op_q;
  logic [DATA_BITS-1:0] pattern_q;
  logic                 done_q;
  logic                 fail_q;
  logic [ADDR_BITS-1:0] fail_addr_q;
  logic [2:0]           fail_elem_q;
  logic [CNT_BITS-1:0]  err_q;
  logic [CNT_BITS-1:0]  err_d;

  logic                 run;
  logic [3:0]           op_idx;
  logic                 op_write;
  logic [DATA_BITS-1:0] exp_word;
  logic                 last_op;
  logic                 miscompare;
  logic                 start_ok;
  logic [2:0]           elem_next;
  logic                 elem_end;
  logic                 addr_load;
  logic                 addr_load_up;
  logic                 addr_step;
  logic [ADDR_BITS-1:0] addr;
  logic                 addr_first;
  logic                 addr_last;

  assign run        = (state_q == ST_RUN);
  assign op_idx     = op_index(elem_q, op_q);
  assign op_write   = OP_WRITE[op_idx];
  assign exp_word   = OP_INV[op_idx] ? ~pattern_q : pattern_q;
  assign last_op    = !ELEM_TWO_OPS[elem_q] || op_q;
  assign miscompare = run && !op_write && (bus.mem_rdata != exp_word);
  assign err_d      = (err_q == '1) ? err_q : err_q + 1'b1;
  assign start_ok   = (state_q != ST_RUN) && bus.start;
  assign elem_next  = elem_q + 3'd1;
  assign elem_end   = run && last_op && addr_last;

  // The counter is reloaded on start and whenever a new element begins.
  assign addr_load    = start_ok || (elem_end && (elem_q != LAST_ELEM));
  assign addr_load_up = start_ok ? 1'b1 : ELEM_UP[elem_next];
  assign addr_step    = run && last_op && !addr_last;

  march_addr_gen #(
    .ADDR_BITS (ADDR_BITS)
  ) u_addr_gen (
    .clk     (clk),
    .reset   (reset),
    .load_i  (addr_load),
    .up_i    (addr_load_up),
    .step_i  (addr_step),
    .addr_o  (addr),
    .first_o (addr_first),
    .last_o  (addr_last)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      elem_q      <= '0;
      op_q        <= 1'b0;
      pattern_q   <= '0;
      done_q      <= 1'b0;
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
      err_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q     <= ST_RUN;
            pattern_q   <= bus.pattern;
            elem_q      <= '0;
            op_q        <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            err_q       <= '0;
          end
        end
        ST_RUN: begin
          if (miscompare) begin
            err_q  <= err_d;
            fail_q <= 1'b1;
            if (!fail_q) begin
              fail_addr_q <= addr;
              fail_elem_q <= elem_q;
            end
          end
          if (!last_op) begin
            op_q <= 1'b1;
          end else begin
            op_q <= 1'b0;
            if (addr_last) begin
              if (elem_q == LAST_ELEM) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else begin
                elem_q <= elem_next;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // After any reload the counter must sit on the element's starting address.
  assert property (@(posedge clk) disable iff (!reset) addr_load |=> addr_first);

  assign bus.busy      = run;
  assign bus.done      = done_q;
  assign bus.fail      = fail_q;
  assign bus.fail_addr = fail_addr_q;
  assign bus.fail_elem = fail_elem_q;
  assign bus.err_count = err_q;
  assign bus.mem_we    = run && op_write;
  assign bus.mem_addr  = run ? addr : '0;
  assign bus.mem_wdata = (run && op_write) ? exp_word : '0;

endmodule
